// File: rtl/deccnt_scan.sv
// Debounced up/down BCD counter with a multiplexed seven-segment display.
// Define DECCNT_AUTO_EN to add the run/direction auto-step logic on btnc/btnr.
module deccnt_scan #(
  parameter int DIGITS    = 4,
  parameter int DB_CYCLES = 250000,
  parameter int SCAN_DIV  = 50000,
  parameter int AUTO_DIV  = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnu,
  input  logic        btnd,
  input  logic        btnl,
  input  logic        btnc,
  input  logic        btnr,
  output logic [11:0] seg,
  output logic [7:0]  led
);

`ifdef DECCNT_AUTO_EN
  localparam int NB = 5;
`else
  localparam int NB = 3;
`endif
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int SW  = $clog2(SCAN_DIV + 1);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4:0]    btn_raw;
  logic [NB-1:0] press;

  assign btn_raw = {btnr, btnc, btnl, btnd, btnu};

  // Per button: 2-flop synchroniser, stable-count debouncer, rising-edge pulse.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_btn
      logic [1:0]     sync_reg;
      logic           lvl_reg;
      logic [DBW-1:0] db_cnt_reg;
      logic           press_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_reg   <= 2'b00;
          lvl_reg    <= 1'b0;
          db_cnt_reg <= '0;
          press_reg  <= 1'b0;
        end else begin
          sync_reg  <= {sync_reg[0], btn_raw[gi]};
          press_reg <= 1'b0;
          if (sync_reg[1] == lvl_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DBW'(DB_CYCLES - 1)) begin
            lvl_reg    <= sync_reg[1];
            db_cnt_reg <= '0;
            press_reg  <= sync_reg[1];
          end else begin
            db_cnt_reg <= db_cnt_reg + DBW'(1);
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic up_p, dn_p, clr_p, manual;
  assign up_p   = press[0];
  assign dn_p   = press[1];
  assign clr_p  = press[2];
  assign manual = up_p | dn_p | clr_p;

  logic run_reg, dir_reg, auto_step;

`ifdef DECCNT_AUTO_EN
  localparam int AW = $clog2(AUTO_DIV + 1);
  logic [AW-1:0] pre_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_reg <= 1'b0;
      dir_reg <= 1'b0;
      pre_reg <= '0;
    end else begin
      if (press[3]) run_reg <= ~run_reg;
      if (press[4]) dir_reg <= ~dir_reg;
      if (!run_reg || press[3])
        pre_reg <= '0;
      else if (pre_reg == AW'(AUTO_DIV - 1))
        pre_reg <= '0;
      else
        pre_reg <= pre_reg + AW'(1);
    end
  end

  assign auto_step = run_reg && (pre_reg == AW'(AUTO_DIV - 1));
`else
  logic unused_btn;
  assign unused_btn = btnc ^ btnr;
  assign run_reg    = 1'b0;
  assign dir_reg    = 1'b0;
  assign auto_step  = 1'b0;
`endif

  logic step_up, step_dn;
  assign step_up = (up_p & ~dn_p) | (auto_step & ~manual & ~dir_reg);
  assign step_dn = (dn_p & ~up_p) | (auto_step & ~manual &  dir_reg);

  logic [4*DIGITS-1:0] bcd_reg, inc_val, dec_val;
  logic                carry, borrow;

  // Ripple decimal carry/borrow; the final carry/borrow out marks a wrap.
  always_comb begin
    inc_val = bcd_reg;
    dec_val = bcd_reg;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry)
        inc_val[4*i +: 4] = (bcd_reg[4*i +: 4] == 4'd9) ? 4'd0 : bcd_reg[4*i +: 4] + 4'd1;
      if (borrow)
        dec_val[4*i +: 4] = (bcd_reg[4*i +: 4] == 4'd0) ? 4'd9 : bcd_reg[4*i +: 4] - 4'd1;
      carry  = carry  && (bcd_reg[4*i +: 4] == 4'd9);
      borrow = borrow && (bcd_reg[4*i +: 4] == 4'd0);
    end
  end

  logic upf_reg, dnf_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_reg <= '0;
      upf_reg <= 1'b0;
      dnf_reg <= 1'b0;
    end else if (clr_p) begin
      bcd_reg <= '0;
      upf_reg <= 1'b0;
      dnf_reg <= 1'b0;
    end else if (step_up) begin
      bcd_reg <= inc_val;
      if (carry) upf_reg <= 1'b1;
    end else if (step_dn) begin
      bcd_reg <= dec_val;
      if (borrow) dnf_reg <= 1'b1;
    end
  end

  logic [SW-1:0] scan_cnt_reg;
  logic [IW-1:0] idx_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_reg <= '0;
      idx_reg      <= '0;
    end else if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
      scan_cnt_reg <= '0;
      idx_reg      <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + IW'(1);
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SW'(1);
    end
  end

  logic [3:0] an_next;
  logic [3:0] cur_digit;
  logic [7:0] cath_next;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_an
      if (gi < DIGITS) begin : g_used
        assign an_next[gi] = (idx_reg != IW'(gi));
      end else begin : g_off
        assign an_next[gi] = 1'b1;
      end
    end
  endgenerate

  assign cur_digit = bcd_reg[{idx_reg, 2'b00} +: 4];

  always_comb begin
    cath_next = 8'hFF;
    case (cur_digit)
      4'd0: cath_next = 8'hC0;
      4'd1: cath_next = 8'hF9;
      4'd2: cath_next = 8'hA4;
      4'd3: cath_next = 8'hB0;
      4'd4: cath_next = 8'h99;
      4'd5: cath_next = 8'h92;
      4'd6: cath_next = 8'h82;
      4'd7: cath_next = 8'hF8;
      4'd8: cath_next = 8'h80;
      4'd9: cath_next = 8'h90;
      default: cath_next = 8'hFF;
    endcase
  end

  logic [11:0] seg_reg;
  logic [7:0]  led_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_reg <= 12'hEC0;
      led_reg <= 8'h00;
    end else begin
      seg_reg <= {an_next, cath_next};
      led_reg <= {4'b0000, dir_reg, run_reg, dnf_reg, upf_reg};
    end
  end

  assign seg = seg_reg;
  assign led = led_reg;

endmodule

// File: doc/deccnt_scan.md
DECCNT_SCAN -- requirements
Module: deccnt_scan

Interface
REQ-001 The block SHALL expose parameter DIGITS, default 4, meaning number of BCD digits counted and displayed (legal 1..4).
REQ-002 The block SHALL expose parameter DB_CYCLES, default 250000, meaning consecutive stable cycles required before a button level is accepted.
REQ-003 The block SHALL expose parameter SCAN_DIV, default 50000, meaning clock cycles each digit is driven before the scan advances.
REQ-004 The block SHALL expose parameter AUTO_DIV, default 5000000, meaning clock cycles between auto-run steps (used only with DECCNT_AUTO_EN).
REQ-005 CLK  input  1  single system clock; all state on rising edge.
REQ-006 RESET  input  1  asynchronous, active-low reset.
REQ-007 BTNU  input  1  raw button, count up one step.
REQ-008 BTND  input  1  raw button, count down one step.
REQ-009 BTNL  input  1  raw button, clear counter and flags.
REQ-010 BTNC  input  1  raw button, toggle auto-run (DECCNT_AUTO_EN only).
REQ-011 BTNR  input  1  raw button, toggle auto-run direction (DECCNT_AUTO_EN only).
REQ-012 SEG  output  12  [11:8] active-low anodes digit 3..0, [7:0] active-low cathodes {dp,g,f,e,d,c,b,a}.
REQ-013 LED  output  8  [0] sticky up-wrap, [1] sticky down-wrap, [2] run, [3] direction (1=down), [7:4] constant 0.

Function
REQ-014 Each button SHALL pass a 2-flop synchroniser, then a debouncer accepting a new level only after DB_CYCLES consecutive equal synchronised samples.
REQ-015 A 0->1 transition of a debounced level SHALL produce exactly one single-cycle press pulse; holding a button SHALL NOT repeat.
REQ-016 Counter SHALL hold DIGITS BCD digits, range 0..10^DIGITS-1, each digit always 0..9.
REQ-017 Up pulse: counter +1 with decimal carry, visible on the register the cycle after the pulse; at maximum it SHALL wrap to 0 and set LED[0].
REQ-018 Down pulse: counter -1 with decimal borrow; at 0 it SHALL wrap to maximum and set LED[1].
REQ-019 Clear pulse SHALL zero counter, LED[0], LED[1] next cycle, overriding any same-cycle up/down/auto step.
REQ-020 Up and down pulses in the same cycle (no clear) SHALL leave counter and flags unchanged.
REQ-021 Scan counter SHALL advance digit index every SCAN_DIV cycles, 0,1,..,DIGITS-1, then wrap to 0.
REQ-022 Exactly one anode (the indexed digit) SHALL be low; anodes >= DIGITS SHALL stay high always.
REQ-023 Cathodes SHALL show standard 7-seg decode of the indexed digit (0=8'hC0, 1=8'hF9, ... 9=8'h90); dp always off (1).
REQ-024 SEG and LED SHALL be registered outputs, updated one cycle after the internal state they reflect.

Reset
REQ-025 RESET low SHALL immediately clear synchronisers, debouncers (accepted level 0), counter, flags, run, direction, scan index, prescalers.
REQ-026 During and right after reset SEG SHALL be 12'hEC0 (digit 0, showing 0) and LED SHALL be 8'h00.
REQ-027 Reset asserted mid-count or mid-debounce SHALL abort; a button already held at release SHALL need DB_CYCLES stable cycles and then produce one press.

Configuration
REQ-028 Macro DECCNT_AUTO_EN defined: BTNC press toggles run (LED[2]); BTNR press toggles direction (LED[3]); while run=1 a prescaler SHALL issue one step every AUTO_DIV cycles in the current direction, with wrap/flag rules of REQ-017/018.
REQ-029 With DECCNT_AUTO_EN, an auto step coinciding with a manual up/down/clear pulse SHALL be dropped; prescaler restarts from 0 when run is toggled on.
REQ-030 Macro DECCNT_AUTO_EN undefined: no auto logic; BTNC/BTNR ignored; LED[3:2]=0.

Verification (DIGITS=2, DB_CYCLES=4, SCAN_DIV=8, AUTO_DIV=16)
REQ-031 Reset released, no buttons -> SEG=12'hEC0, LED=8'h00; after 8 cycles SEG=12'hDC0.
REQ-032 BTNU glitch high 2 cycles -> counter stays 0; BTNU held 20 cycles -> counter 01 exactly once.
REQ-033 Counter 99, BTNU press -> 00, LED[0]=1; BTND press from 00 -> 99, LED[1]=1; BTNL press -> 00, LED=8'h00.
REQ-034 BTNU and BTND pulses same cycle at 05 -> 05; BTNL and BTNU same cycle -> 00.
REQ-035 DECCNT_AUTO_EN: BTNC press -> LED[2]=1, counter 01 after 16 cycles, 02 after 32; BTNR press -> counts down; RESET mid-run -> 00, LED=8'h00.
